// File: rtl/rdcla_mp_seq_if.sv
// rtl/rdcla_mp_seq_if.sv - request/response and adder-side signals of the multi-precision add sequencer
interface rdcla_mp_seq_if #(
   parameter int WORDS = 4
);
   logic                  start;
   logic [32*WORDS-1:0]   op_a;
   logic [32*WORDS-1:0]   op_b;
   logic                  cin;
   logic                  busy;
   logic                  done;
   logic [32*WORDS-1:0]   sum;
   logic                  cout;
   logic [31:0]           add_a;
   logic [31:0]           add_b;
   logic                  add_cin;
   logic [31:0]           add_s;
   logic                  add_cout;

   modport slave (
      input  start, op_a, op_b, cin, add_s, add_cout,
      output busy, done, sum, cout, add_a, add_b, add_cin
   );

   modport master (
      output start, op_a, op_b, cin, add_s, add_cout,
      input  busy, done, sum, cout, add_a, add_b, add_cin
   );
endinterface

// File: rtl/rdcla_mp_seq.sv
// rtl/rdcla_mp_seq.sv - WORDS x 32-bit adder sequencer around the 32-bit CLA, LS limb first
module rdcla_mp_seq #(
   parameter int WORDS   = 4,
   parameter int ADD_LAT = 5
) (
   input  logic             clk,
   input  logic             rst,
   rdcla_mp_seq_if.slave    bus
);
   localparam int W  = 32 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CW = $clog2(ADD_LAT + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    a_rem_q, a_rem_d;
   logic [W-1:0]    b_rem_q, b_rem_d;
   logic [31:0]     add_a_q, add_a_d;
   logic [31:0]     add_b_q, add_b_d;
   logic            add_cin_q, add_cin_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      a_rem_d   = a_rem_q;
      b_rem_d   = b_rem_q;
      add_a_d   = add_a_q;
      add_b_d   = add_b_q;
      add_cin_d = add_cin_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               // Remaining limbs are kept pre-shifted so the next limb is always at [31:0]
               a_rem_d   = bus.op_a >> 32;
               b_rem_d   = bus.op_b >> 32;
               add_a_d   = bus.op_a[31:0];
               add_b_d   = bus.op_b[31:0];
               add_cin_d = bus.cin;
               idx_d     = '0;
               cnt_d     = '0;
               busy_d    = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (cnt_q == CW'(ADD_LAT - 1)) begin
               for (int i = 0; i < WORDS; i++) begin
                  if (idx_q == IW'(i)) sum_d[i*32 +: 32] = bus.add_s;
               end
               if (idx_q == IW'(WORDS - 1)) begin
                  cout_d  = bus.add_cout;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  idx_d     = idx_q + 1'b1;
                  cnt_d     = '0;
                  add_a_d   = a_rem_q[31:0];
                  add_b_d   = b_rem_q[31:0];
                  add_cin_d = bus.add_cout;
                  a_rem_d   = a_rem_q >> 32;
                  b_rem_d   = b_rem_q >> 32;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         a_rem_q   <= '0;
         b_rem_q   <= '0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         add_cin_q <= 1'b0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         a_rem_q   <= a_rem_d;
         b_rem_q   <= b_rem_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         add_cin_q <= add_cin_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.sum     = sum_q;
   assign bus.cout    = cout_q;
   assign bus.add_a   = add_a_q;
   assign bus.add_b   = add_b_q;
   assign bus.add_cin = add_cin_q;
endmodule

// File: tb/tb_rdcla_mp_seq.sv
// tb/tb_rdcla_mp_seq.sv - bench for rdcla_mp_seq with a delayed adder model and a result scoreboard
module tb_rdcla_mp_seq;
   localparam int WORDS = 4;
   localparam int LAT   = 5;
   localparam int N     = WORDS * LAT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   rdcla_mp_seq_if #(.WORDS(WORDS)) bus();

   rdcla_mp_seq #(.WORDS(WORDS), .ADD_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Adder model: result of the inputs driven at edge T becomes visible for sampling at edge T+LAT
   logic [32:0] pipe [0:LAT-2];
   always @(posedge clk) begin
      pipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + 33'(bus.add_cin);
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.add_s    = pipe[LAT-2][31:0];
   assign bus.add_cout = pipe[LAT-2][32];

   logic [128:0] exp_q[$];

   task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 129'(bus.done), 129'(0));
         end else begin
            chk("result", {bus.cout, bus.sum}, exp_q.pop_front());
         end
      end
   end

   function automatic logic carry_into(input logic [127:0] a, input logic [127:0] b, input logic c, input int limb);
      logic [128:0] mask;
      logic [128:0] t;
      if (limb == 0) return c;
      mask = (129'd1 << (32 * limb)) - 129'd1;
      t = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 129'(c);
      return t[32 * limb];
   endfunction

   task automatic launch(input logic [127:0] a, input logic [127:0] b, input logic c, input logic [128:0] exp);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      bus.cin   = c;
      exp_q.push_back(exp);
   endtask

   // Called at the negedge before the accepting edge T0; returns at the negedge after T0+N
   task automatic check_op(input logic [127:0] a, input logic [127:0] b, input logic c,
                           input bit ign, input bit hold,
                           input logic [127:0] ha, input logic [127:0] hb, input logic hc);
      int limb;
      @(negedge clk);
      if (hold) begin
         bus.op_a = ha;
         bus.op_b = hb;
         bus.cin  = hc;
         exp_q.push_back({1'b0, ha} + {1'b0, hb} + 129'(hc));
      end else begin
         bus.start = 1'b0;
         bus.op_a  = ~a;
         bus.op_b  = ~b;
         bus.cin   = ~c;
      end
      for (int j = 0; j < N; j++) begin
         limb = j / LAT;
         chk("busy_run", 129'(bus.busy), 129'(1));
         chk("done_low", 129'(bus.done), 129'(0));
         chk("add_a", 129'(bus.add_a), 129'(a[32*limb +: 32]));
         chk("add_b", 129'(bus.add_b), 129'(b[32*limb +: 32]));
         chk("add_cin", 129'(bus.add_cin), 129'(carry_into(a, b, c, limb)));
         if (ign && !hold && j == 6) begin
            bus.start = 1'b1;
            bus.op_a  = {$urandom, $urandom, $urandom, $urandom};
            bus.op_b  = {$urandom, $urandom, $urandom, $urandom};
         end
         if (ign && !hold && j == 7) bus.start = 1'b0;
         @(negedge clk);
      end
      chk("done_pulse", 129'(bus.done), 129'(1));
      chk("busy_done", 129'(bus.busy), 129'(0));
   endtask

   typedef struct {
      logic [127:0] a;
      logic [127:0] b;
      logic         c;
      logic [127:0] s;
      logic         co;
   } vec_t;

   vec_t vt [6];

   initial begin
      logic [127:0] ra, rb;
      logic         rc;
      int           done_seen;

      vt[0] = '{128'd123, 128'd123, 1'b1, 128'd247, 1'b0};
      vt[1] = '{128'hFFFF_FFFF, 128'd1, 1'b0, 128'h1_0000_0000, 1'b0};
      vt[2] = '{{128{1'b1}}, 128'd0, 1'b1, 128'd0, 1'b1};
      vt[3] = '{{128{1'b1}}, {128{1'b1}}, 1'b0, {{127{1'b1}}, 1'b0}, 1'b1};
      vt[4] = '{128'd0, 128'd0, 1'b0, 128'd0, 1'b0};
      vt[5] = '{{1'b1, 127'd0}, {1'b1, 127'd5}, 1'b1, 128'd6, 1'b1};

      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      bus.cin   = 1'b0;
      for (int i = 0; i < LAT - 1; i++) pipe[i] = '0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 129'(bus.busy), 129'(0));
      chk("rst_done", 129'(bus.done), 129'(0));
      chk("rst_sum_cout", {bus.cout, bus.sum}, 129'(0));
      chk("rst_add", {bus.add_cin, bus.add_b, bus.add_a}, 129'(0));
      rst = 1'b0;

      for (int k = 0; k < 6; k++) begin
         launch(vt[k].a, vt[k].b, vt[k].c, {vt[k].co, vt[k].s});
         check_op(vt[k].a, vt[k].b, vt[k].c, 1'b0, 1'b0, '0, '0, 1'b0);
      end

      // start pulse mid-operation is ignored
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      launch(ra, rb, 1'b0, {1'b0, ra} + {1'b0, rb});
      check_op(ra, rb, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

      // start held through done: second op accepted on the done cycle
      launch(vt[1].a, vt[1].b, vt[1].c, {vt[1].co, vt[1].s});
      check_op(vt[1].a, vt[1].b, vt[1].c, 1'b0, 1'b1, vt[2].a, vt[2].b, vt[2].c);
      check_op(vt[2].a, vt[2].b, vt[2].c, 1'b0, 1'b0, '0, '0, 1'b0);

      // reset mid-operation at T0+12
      launch(vt[3].a, vt[3].b, vt[3].c, {vt[3].co, vt[3].s});
      @(negedge clk);
      bus.start = 1'b0;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_busy", 129'(bus.busy), 129'(0));
      chk("midrst_done", 129'(bus.done), 129'(0));
      chk("midrst_sum_cout", {bus.cout, bus.sum}, 129'(0));
      chk("midrst_add", {bus.add_cin, bus.add_b, bus.add_a}, 129'(0));
      rst = 1'b0;
      done_seen = 0;
      for (int j = 0; j < 2 * N; j++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      chk("no_done_after_rst", 129'(done_seen), 129'(0));

      for (int k = 0; k < 1000; k++) begin
         ra = {$urandom, $urandom, $urandom, $urandom};
         rb = {$urandom, $urandom, $urandom, $urandom};
         if (k % 7 == 0) rb = ~ra;
         rc = 1'($urandom_range(0, 1));
         launch(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 129'(rc));
         check_op(ra, rb, rc, 1'b0, 1'b0, '0, '0, 1'b0);
      end

      @(negedge clk);
      chk("scoreboard_empty", 129'(exp_q.size()), 129'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rdcla_mp_seq.md
Name: rdcla_mp_seq

Overview:
Multi-precision add sequencer that sits around the 32-bit recursive-doubling CLA (`rdcla`).
- Upstream role: latches wide operands and drives the adder's a/b/cin one 32-bit limb at a time, least significant limb first.
- Downstream role: captures the adder's s/cout after the adder's settle latency, chains cout into the next limb's cin, and assembles the wide sum.
- Gives the team WORDS×32-bit addition with a start/busy/done handshake on top of the existing adder.

Parameters:
- WORDS, 4: number of 32-bit limbs; operand/result width is 32*WORDS; WORDS >= 1.
- ADD_LAT, 5: clk cycles from the edge that drives add_a/add_b/add_cin until add_s/add_cout are valid; ADD_LAT >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new addition; sampled only in IDLE.
- op_a  in  32*WORDS  operand A; sampled on the accepting edge.
- op_b  in  32*WORDS  operand B; sampled on the accepting edge.
- cin  in  1  carry into limb 0; sampled on the accepting edge.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse when sum/cout update.
- sum  out  32*WORDS  result, held until the next completion.
- cout  out  1  carry out of the top limb, held with sum.
- add_a  out  32  limb of A to the adder a input (registered).
- add_b  out  32  limb of B to the adder b input (registered).
- add_cin  out  1  to the adder cin (registered).
- add_s  in  32  from the adder s output.
- add_cout  in  1  from the adder cout output.

Behaviour:
- Reset (sync, rst=1 at a rising edge): state=IDLE; busy=0, done=0, sum=0, cout=0, add_a=0, add_b=0, add_cin=0; limb index and wait counter cleared. Reset wins over every other event, including mid-operation; the in-flight result is discarded and sum/cout read 0.
- FSM has 2 states: IDLE, RUN.
- IDLE: at edge T0 with start=1:
  - latch op_a, op_b, cin;
  - drive add_a = op_a[31:0], add_b = op_b[31:0], add_cin = cin;
  - idx=0, cnt=0, busy=1; go to RUN.
  - start=0 leaves all outputs unchanged.
- RUN: cnt increments every edge.
- Capture edge: the edge where cnt reaches ADD_LAT, i.e. T0 + (idx+1)*ADD_LAT.
  - write add_s into sum limb idx; carry register = add_cout.
  - If idx < WORDS-1: idx++, cnt=0, and in the same edge drive add_a/add_b = limb idx+1 and add_cin = add_cout.
  - If idx = WORDS-1: cout = add_cout, done=1, busy=0, go to IDLE. add_a/add_b/add_cin hold their last values.
- add_a/add_b/add_cin change only at T0 and at capture edges. They are stable for exactly ADD_LAT cycles per limb.
- Latency: done rises at edge T0 + WORDS*ADD_LAT (20 cycles with the defaults). Throughput is one operation per WORDS*ADD_LAT+1 cycles when start is held.
- done is high for exactly one cycle. The next edge clears it unless a capture completes again.
- start while busy=1 is ignored, not queued. A new op_a/op_b/cin during RUN has no effect.
- start=1 in the cycle where done=1 is accepted, because state is IDLE. The new op starts and done falls on that edge.
- sum limbs already captured are overwritten in place during an operation. sum is only architecturally valid when qualified by done or by busy=0 after a done.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(32*WORDS+1). Wrap-around at all-ones propagates through every limb via add_cout.

Test Plan:
- Defaults, bench adder model with 5-cycle delay. A=123, B=123, cin=1 -> done at T0+20, sum=247, cout=0. busy high for cycles T0..T0+19.
- A=0x00000000_00000000_00000000_FFFFFFFF, B=1, cin=0 -> sum=0x00000000_00000000_00000001_00000000, cout=0. add_cin=1 observed for limb 1.
- A=all ones (128 bits), B=0, cin=1 -> sum=0, cout=1. Carry chains through all 4 limbs.
- Start pulse at T0+7 with different operands during an operation -> ignored; first result unchanged. Start held high through done -> second op accepted on the done cycle; its done arrives 21 cycles after the first done.
- rst=1 at T0+12 -> next cycle busy=0, done=0, sum=0, cout=0, add_*=0. No done pulse follows.
- Per-limb check: add_a/add_b/add_cin constant over each 5-cycle window. 1000 random 128-bit operand/cin sets match the reference wide sum.
